// File: rtl/audio_i2s_frame_ctrl.sv
// ---------------------------------------------------------------------------
// audio_i2s_frame_ctrl
//
// Frame sequencer for the I2S DAC output path. A free-running 6-bit counter on
// the bit clock produces DACLRCK (32 BCLK left slot, 32 BCLK right slot). The
// block fetches one stereo sample per frame from the synth engine with a
// request/valid handshake, and commits it to the serializer-facing outputs at
// the mid-left-slot point (count 16). The serializer loads near counts 31 and
// 63, so the committed words are always stable while it loads. When the engine
// misses the window, the frame is an underrun: depending on UNDERRUN_HOLD the
// outputs go to zero or repeat the last committed word, and a saturating
// counter records the event.
//
// Parameters
//   AUD_BIT_DEPTH  sample width of input and output words
//   UNDERRUN_HOLD  0: commit zero on underrun, 1: repeat last committed word
//
// Ports
//   reset_reg_N       in   asynchronous active-low reset
//   iAUDB_CLK         in   audio bit clock, all logic on posedge
//   i_enable          in   1 = fetch samples, 0 = mute (sampled at count 63->0)
//   i_clear_underrun  in   synchronous clear of o_underrun_cnt (wins over +1)
//   i_sample_valid    in   engine data valid, accepted only while requesting
//   i_lsample         in   left sample, two's complement
//   i_rsample         in   right sample, two's complement
//   o_AUD_DACLRCK     out  word clock, 0 = left slot, 1 = right slot
//   o_sample_req      out  request to the engine for this frame's sample
//   o_lsound_out      out  committed left word
//   o_rsound_out      out  committed right word
//   o_frame_strobe    out  one-cycle pulse on each commit
//   o_underrun_cnt    out  saturating underrun count
// ---------------------------------------------------------------------------
module audio_i2s_frame_ctrl #(
    parameter int AUD_BIT_DEPTH = 24,
    parameter bit UNDERRUN_HOLD = 1'b0
) (
    input  logic                     reset_reg_N,
    input  logic                     iAUDB_CLK,
    input  logic                     i_enable,
    input  logic                     i_clear_underrun,
    input  logic                     i_sample_valid,
    input  logic [AUD_BIT_DEPTH-1:0] i_lsample,
    input  logic [AUD_BIT_DEPTH-1:0] i_rsample,
    output logic                     o_AUD_DACLRCK,
    output logic                     o_sample_req,
    output logic [AUD_BIT_DEPTH-1:0] o_lsound_out,
    output logic [AUD_BIT_DEPTH-1:0] o_rsound_out,
    output logic                     o_frame_strobe,
    output logic [7:0]               o_underrun_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_FULL = 2'd2;

    // The request starts on the edge where the counter wraps to 0, so the
    // enable decision is taken while the counter still reads 63.
    localparam logic [5:0] CNT_LAST   = 6'd63;
    localparam logic [5:0] CNT_COMMIT = 6'd16;

    logic [5:0]               frame_cnt_q, frame_cnt_d;
    logic [1:0]               state_q, state_d;
    logic [AUD_BIT_DEPTH-1:0] pend_l_q, pend_l_d;
    logic [AUD_BIT_DEPTH-1:0] pend_r_q, pend_r_d;
    logic [AUD_BIT_DEPTH-1:0] lsound_q, lsound_d;
    logic [AUD_BIT_DEPTH-1:0] rsound_q, rsound_d;
    logic                     strobe_q, strobe_d;
    logic [7:0]               underrun_cnt_q, underrun_cnt_d;
    logic                     commit_pt;
    logic                     underrun;

    assign commit_pt = (frame_cnt_q == CNT_COMMIT);

    always_comb begin
        frame_cnt_d = frame_cnt_q + 6'd1;
        state_d     = state_q;
        pend_l_d    = pend_l_q;
        pend_r_d    = pend_r_q;
        lsound_d    = lsound_q;
        rsound_d    = rsound_q;
        strobe_d    = 1'b0;
        underrun    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if ((frame_cnt_q == CNT_LAST) && i_enable) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // The commit point closes the window: a valid arriving in the
                // same cycle is too late and is dropped.
                if (commit_pt) begin
                    underrun = 1'b1;
                    state_d  = ST_IDLE;
                end else if (i_sample_valid) begin
                    pend_l_d = i_lsample;
                    pend_r_d = i_rsample;
                    state_d  = ST_FULL;
                end
            end
            ST_FULL: begin
                if (commit_pt) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every frame commits something: the fetched sample, the held word on
        // a hold-policy underrun, or silence.
        if (commit_pt) begin
            strobe_d = 1'b1;
            if (state_q == ST_FULL) begin
                lsound_d = pend_l_q;
                rsound_d = pend_r_q;
            end else if (!(underrun && UNDERRUN_HOLD)) begin
                lsound_d = '0;
                rsound_d = '0;
            end
        end

        if (i_clear_underrun) begin
            underrun_cnt_d = 8'd0;
        end else if (underrun && (underrun_cnt_q != 8'hFF)) begin
            underrun_cnt_d = underrun_cnt_q + 8'd1;
        end else begin
            underrun_cnt_d = underrun_cnt_q;
        end
    end

    always_ff @(posedge iAUDB_CLK or negedge reset_reg_N) begin
        if (!reset_reg_N) begin
            frame_cnt_q    <= 6'd0;
            state_q        <= ST_IDLE;
            pend_l_q       <= '0;
            pend_r_q       <= '0;
            lsound_q       <= '0;
            rsound_q       <= '0;
            strobe_q       <= 1'b0;
            underrun_cnt_q <= 8'd0;
        end else begin
            frame_cnt_q    <= frame_cnt_d;
            state_q        <= state_d;
            pend_l_q       <= pend_l_d;
            pend_r_q       <= pend_r_d;
            lsound_q       <= lsound_d;
            rsound_q       <= rsound_d;
            strobe_q       <= strobe_d;
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign o_AUD_DACLRCK  = frame_cnt_q[5];
    assign o_sample_req   = (state_q == ST_REQ);
    assign o_lsound_out   = lsound_q;
    assign o_rsound_out   = rsound_q;
    assign o_frame_strobe = strobe_q;
    assign o_underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_audio_i2s_frame_ctrl.sv
// ---------------------------------------------------------------------------
// Testbench for audio_i2s_frame_ctrl. Two instances share all stimulus: one
// with the zero-on-underrun policy and one with the hold policy. Stimulus is
// applied a whole frame at a time; a frame-level reference model predicts the
// committed words, request window and underrun count from the frame's
// parameters (enable, valid cycle, clear cycle).
// ---------------------------------------------------------------------------
module tb_audio_i2s_frame_ctrl;

    localparam int W = 24;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         clr   = 1'b0;
    logic         valid = 1'b0;
    logic [W-1:0] ls    = '0;
    logic [W-1:0] rs    = '0;

    logic         lrck0, req0, strobe0, lrck1, req1, strobe1;
    logic [W-1:0] lo0, ro0, lo1, ro1;
    logic [7:0]   uc0, uc1;

    int n_pass  = 0;
    int n_total = 0;
    int cnt_m   = 0;

    // Reference model: committed words per instance and underrun count.
    logic [W-1:0]   m_l0 = '0, m_r0 = '0, m_l1 = '0, m_r1 = '0;
    int             m_uc = 0;
    int             e_cnt, e_first, e_last;
    logic [4*W-1:0] e_pre, e_post;

    // Per-frame observations.
    int             o_req_cnt, o_req_first, o_req_last;
    int             o_strobe_cnt, o_strobe_k, o_lrck_err, o_stab_err, o_pair_err;
    int             o_uc0, o_uc1;
    logic [4*W-1:0] o_pre, o_post;

    always #5 clk = ~clk;

    audio_i2s_frame_ctrl #(.AUD_BIT_DEPTH(W), .UNDERRUN_HOLD(1'b0)) dut0 (
        .reset_reg_N      (rst_n),
        .iAUDB_CLK        (clk),
        .i_enable         (en),
        .i_clear_underrun (clr),
        .i_sample_valid   (valid),
        .i_lsample        (ls),
        .i_rsample        (rs),
        .o_AUD_DACLRCK    (lrck0),
        .o_sample_req     (req0),
        .o_lsound_out     (lo0),
        .o_rsound_out     (ro0),
        .o_frame_strobe   (strobe0),
        .o_underrun_cnt   (uc0)
    );

    audio_i2s_frame_ctrl #(.AUD_BIT_DEPTH(W), .UNDERRUN_HOLD(1'b1)) dut1 (
        .reset_reg_N      (rst_n),
        .iAUDB_CLK        (clk),
        .i_enable         (en),
        .i_clear_underrun (clr),
        .i_sample_valid   (valid),
        .i_lsample        (ls),
        .i_rsample        (rs),
        .o_AUD_DACLRCK    (lrck1),
        .o_sample_req     (req1),
        .o_lsound_out     (lo1),
        .o_rsound_out     (ro1),
        .o_frame_strobe   (strobe1),
        .o_underrun_cnt   (uc1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cnt_m = (cnt_m + 1) % 64;
    endtask

    // Frame-level model. va = cycle of the valid pulse (-1 = none),
    // clr_k = cycle of a clear pulse (-1 = none).
    task automatic model_frame(input bit f_en, input int va, input logic [W-1:0] l,
                               input logic [W-1:0] r, input int clr_k);
        bit acc;
        acc   = f_en && (va >= 0) && (va <= 15);
        e_pre = {m_l0, m_r0, m_l1, m_r1};
        if (!f_en) begin
            m_l0 = '0; m_r0 = '0; m_l1 = '0; m_r1 = '0;
        end else if (acc) begin
            m_l0 = l; m_r0 = r; m_l1 = l; m_r1 = r;
        end else begin
            m_l0 = '0; m_r0 = '0;
        end
        e_post = {m_l0, m_r0, m_l1, m_r1};
        if (clr_k >= 0 && clr_k <= 15) m_uc = 0;
        if (clr_k == 16) m_uc = 0;
        else if (f_en && !acc) m_uc = (m_uc >= 255) ? 255 : m_uc + 1;
        if (clr_k >= 17 && clr_k <= 62) m_uc = 0;
        e_cnt   = !f_en ? 0 : (acc ? va + 1 : 17);
        e_first = f_en ? 0 : -1;
        e_last  = !f_en ? -1 : (acc ? va : 16);
    endtask

    // Drives one full frame starting with the counter at 63 and records what
    // both instances did. en_k/en_v change i_enable mid-frame.
    task automatic run_frame(input bit f_en, input int va, input logic [W-1:0] l,
                             input logic [W-1:0] r, input int en_k, input bit en_v,
                             input int clr_k);
        logic [4*W-1:0] cur;
        model_frame(f_en, va, l, r, clr_k);
        en = f_en;
        o_req_cnt = 0; o_req_first = -1; o_req_last = -1;
        o_strobe_cnt = 0; o_strobe_k = -1; o_lrck_err = 0; o_stab_err = 0; o_pair_err = 0;
        for (int k = 0; k < 64; k++) begin
            tick();
            if (req0) begin
                o_req_cnt++;
                if (o_req_first < 0) o_req_first = k;
                o_req_last = k;
            end
            if (strobe0) begin
                o_strobe_cnt++;
                o_strobe_k = k;
            end
            if ({req1, strobe1, lrck1} !== {req0, strobe0, lrck0}) o_pair_err++;
            if (lrck0 !== (k >= 32)) o_lrck_err++;
            cur = {lo0, ro0, lo1, ro1};
            if (k == 0) o_pre = cur;
            else if (k < 17 && cur !== o_pre) o_stab_err++;
            if (k == 17) o_post = cur;
            else if (k > 17 && cur !== o_post) o_stab_err++;
            if (k == 63) begin
                o_uc0 = int'(uc0);
                o_uc1 = int'(uc1);
            end
            valid = (k == va) && (k != 63);
            clr   = (k == clr_k) && (k != 63);
            ls    = (k == va) ? l : W'($urandom);
            rs    = (k == va) ? r : W'($urandom);
            if (k == en_k) en = en_v;
        end
    endtask

    task automatic test_reset();
        int reqs, lerr, strobes, sk;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        if ({lrck0, req0, strobe0, lo0, ro0, uc0, lrck1, req1, strobe1, lo1, ro1, uc1} !== '0)
            $display("FAIL reset_state: got l0=%h r0=%h l1=%h r1=%h lrck=%b req=%b strobe=%b uc=%0d, expected all zero",
                     lo0, ro0, lo1, ro1, lrck0, req0, strobe0, uc0);
        else n_pass++;
        rst_n = 1'b1;
        cnt_m = 0;
        reqs = 0; lerr = 0; strobes = 0; sk = -1;
        for (int k = 1; k < 64; k++) begin
            tick();
            if (req0 || req1) reqs++;
            if (lrck0 !== (k >= 32) || lrck1 !== (k >= 32)) lerr++;
            if (strobe0) begin strobes++; sk = k; end
        end
        n_total++;
        if (reqs !== 0) $display("FAIL reset_no_req: got %0d request cycles, expected 0", reqs);
        else n_pass++;
        n_total++;
        if (lerr !== 0) $display("FAIL reset_lrck: got %0d wrong LRCK cycles, expected 0", lerr);
        else n_pass++;
        n_total++;
        if (strobes !== 1 || sk !== 17)
            $display("FAIL reset_strobe: got %0d strobes last at cnt %0d, expected 1 at cnt 17", strobes, sk);
        else n_pass++;
        $display("test_reset done: %0d/%0d", n_pass, n_total);
    endtask

    task automatic test_basic();
        int va;
        logic [W-1:0] l, r;
        for (int i = 0; i < 4; i++) begin
            va = (i == 0) ? 3 : int'($urandom_range(0, 15));
            l  = (i == 0) ? 24'h123456 : W'($urandom);
            r  = (i == 0) ? 24'hABCDEF : W'($urandom);
            run_frame(1'b1, va, l, r, -1, 1'b0, -1);
            n_total++;
            if (o_req_cnt !== e_cnt || o_req_first !== e_first || o_req_last !== e_last)
                $display("FAIL basic_req f%0d: got cnt=%0d first=%0d last=%0d, expected cnt=%0d first=%0d last=%0d",
                         i, o_req_cnt, o_req_first, o_req_last, e_cnt, e_first, e_last);
            else n_pass++;
            n_total++;
            if (o_post !== e_post || o_pre !== e_pre)
                $display("FAIL basic_commit f%0d: got pre=%h post=%h, expected pre=%h post=%h", i, o_pre, o_post, e_pre, e_post);
            else n_pass++;
            n_total++;
            if (o_strobe_cnt !== 1 || o_strobe_k !== 17 || o_stab_err !== 0 || o_pair_err !== 0 || o_uc0 !== m_uc)
                $display("FAIL basic_frame f%0d: got strobes=%0d at %0d stab=%0d pair=%0d uc=%0d, expected 1 at 17 0 0 uc=%0d",
                         i, o_strobe_cnt, o_strobe_k, o_stab_err, o_pair_err, o_uc0, m_uc);
            else n_pass++;
            $display("basic frame %0d: va=%0d L=%h R=%h out L=%h R=%h", i, va, l, r, lo0, ro0);
        end
    endtask

    task automatic test_lrck();
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, int'($urandom_range(0, 15)), W'($urandom), W'($urandom), -1, 1'b0, -1);
            n_total++;
            if (o_lrck_err !== 0 || o_req_first !== 0 || o_strobe_cnt !== 1)
                $display("FAIL lrck f%0d: got lrck_err=%0d req_first=%0d strobes=%0d, expected 0 0 1",
                         i, o_lrck_err, o_req_first, o_strobe_cnt);
            else n_pass++;
            $display("lrck frame %0d: lrck_err=%0d req_first=%0d", i, o_lrck_err, o_req_first);
        end
    endtask

    task automatic test_underrun();
        run_frame(1'b1, 5, 24'h000100, 24'h000100, -1, 1'b0, -1);
        for (int i = 0; i < 300; i++) begin
            run_frame(1'b1, -1, '0, '0, -1, 1'b0, -1);
            n_total++;
            if (o_uc0 !== m_uc || o_uc1 !== m_uc || o_post !== e_post || o_req_last !== 16)
                $display("FAIL underrun f%0d: got uc0=%0d uc1=%0d post=%h req_last=%0d, expected uc=%0d post=%h req_last=16",
                         i, o_uc0, o_uc1, o_post, o_req_last, m_uc, e_post);
            else n_pass++;
            if (i < 2 || i > 297)
                $display("underrun frame %0d: uc=%0d out0 L=%h out1 L=%h", i, o_uc0, lo0, lo1);
        end
        n_total++;
        if (uc0 !== 8'd255 || uc1 !== 8'd255)
            $display("FAIL underrun_saturate: got uc0=%0d uc1=%0d, expected 255", uc0, uc1);
        else n_pass++;
    endtask

    task automatic test_boundary();
        logic [W-1:0] l, r;
        int vas[3];
        vas = '{7, 15, 16};
        for (int i = 0; i < 3; i++) begin
            l = W'($urandom);
            r = W'($urandom);
            run_frame(1'b1, vas[i], l, r, -1, 1'b0, (i == 0) ? 40 : -1);
            n_total++;
            if (o_post !== e_post || o_uc0 !== m_uc || o_uc1 !== m_uc || o_req_last !== e_last)
                $display("FAIL boundary va=%0d: got post=%h uc=%0d req_last=%0d, expected post=%h uc=%0d req_last=%0d",
                         vas[i], o_post, o_uc0, o_req_last, e_post, m_uc, e_last);
            else n_pass++;
            $display("boundary va=%0d: out0 L=%h out1 L=%h uc=%0d", vas[i], lo0, lo1, o_uc0);
        end
    endtask

    task automatic test_enable();
        bit fe[4];
        int fva[4], fek[4];
        bit fev[4];
        fe  = '{1'b0, 1'b1, 1'b1, 1'b0};
        fva = '{5, int'($urandom_range(0, 15)), 9, 4};
        fek = '{40, -1, 2, -1};
        fev = '{1'b1, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_frame(fe[i], fva[i], W'($urandom), W'($urandom), fek[i], fev[i], -1);
            n_total++;
            if (o_req_cnt !== e_cnt || o_req_first !== e_first || o_req_last !== e_last)
                $display("FAIL enable_req f%0d: got cnt=%0d first=%0d last=%0d, expected cnt=%0d first=%0d last=%0d",
                         i, o_req_cnt, o_req_first, o_req_last, e_cnt, e_first, e_last);
            else n_pass++;
            n_total++;
            if (o_post !== e_post || o_uc0 !== m_uc)
                $display("FAIL enable_commit f%0d: got post=%h uc=%0d, expected post=%h uc=%0d", i, o_post, o_uc0, e_post, m_uc);
            else n_pass++;
            $display("enable frame %0d: en=%0b req_cycles=%0d out L=%h", i, fe[i], o_req_cnt, lo0);
        end
    endtask

    task automatic test_clear();
        int ck[4];
        ck = '{-1, 16, 5, 30};
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, -1, '0, '0, -1, 1'b0, ck[i]);
            n_total++;
            if (o_uc0 !== m_uc || o_uc1 !== m_uc)
                $display("FAIL clear clr_k=%0d: got uc0=%0d uc1=%0d, expected %0d", ck[i], o_uc0, o_uc1, m_uc);
            else n_pass++;
            $display("clear frame clr_k=%0d: uc=%0d", ck[i], o_uc0);
        end
    endtask

    task automatic test_reset_mid();
        int reqs, lerr;
        en = 1'b1;
        valid = 1'b0;
        for (int k = 0; k < 9; k++) tick();
        n_total++;
        if (req0 !== 1'b1 || req1 !== 1'b1)
            $display("FAIL reset_mid_req: got req0=%b req1=%b at cnt %0d, expected 1", req0, req1, cnt_m);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({lrck0, req0, strobe0, lo0, ro0, uc0, lrck1, req1, strobe1, lo1, ro1, uc1} !== '0)
            $display("FAIL reset_mid_state: got l0=%h l1=%h req=%b uc=%0d, expected all zero", lo0, lo1, req0, uc0);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        cnt_m = 0;
        m_l0 = '0; m_r0 = '0; m_l1 = '0; m_r1 = '0; m_uc = 0;
        reqs = 0; lerr = 0;
        for (int k = 1; k < 64; k++) begin
            tick();
            if (req0 || req1) reqs++;
            if (lrck0 !== (k >= 32)) lerr++;
        end
        n_total++;
        if (reqs !== 0 || lerr !== 0)
            $display("FAIL reset_mid_idle: got req_cycles=%0d lrck_err=%0d, expected 0 0", reqs, lerr);
        else n_pass++;
        run_frame(1'b1, int'($urandom_range(0, 15)), W'($urandom), W'($urandom), -1, 1'b0, -1);
        n_total++;
        if (o_req_first !== 0 || o_req_cnt !== e_cnt || o_post !== e_post)
            $display("FAIL reset_mid_first_req: got first=%0d cnt=%0d post=%h, expected first=0 cnt=%0d post=%h",
                     o_req_first, o_req_cnt, o_post, e_cnt, e_post);
        else n_pass++;
        $display("reset_mid: first req at cnt %0d, out L=%h", o_req_first, lo0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lrck();
        test_underrun();
        test_boundary();
        test_enable();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
